// File: rtl/dco_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dco_pkg : shared constants, types and table generator for dco_sin_cos_gen
// Revision: 1.0
// ----------------------------------------------------------------------------
package dco_pkg;

  localparam int c_DEF_PHASE_BITS      = 32;
  localparam int c_DEF_TABLE_ADDR_BITS = 11;
  localparam int c_DEF_SIN_WIDTH       = 13;

  localparam logic [1:0] c_QUAD_0 = 2'd0;
  localparam logic [1:0] c_QUAD_1 = 2'd1;
  localparam logic [1:0] c_QUAD_2 = 2'd2;
  localparam logic [1:0] c_QUAD_3 = 2'd3;

  localparam logic [15:0] c_LFSR_POLY = 16'hB400;
  localparam logic [15:0] c_LFSR_SEED = 16'hACE1;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } freq_state_e;

  // sin_quarter.mem comes from scripts/gen_sin_quarter.py using
  // T[i] = round((2^(W-1)-1)*sin(2*pi*(i+0.5)/(4Q))); this is the same formula.
  localparam longint c_PI_FX = 64'd3373259426;  // pi * 2^30

  function automatic longint quarter_sin_entry(input int idx, input int depth,
                                               input int width);
    longint x;
    longint x2;
    longint term;
    longint acc;
    longint amp;
    x    = (c_PI_FX * longint'(2 * idx + 1)) / longint'(4 * depth);
    x2   = (x * x) >>> 30;
    term = x;
    acc  = 0;
    for (int k = 0; k < 12; k++) begin
      if ((k % 2) == 0) acc = acc + term;
      else              acc = acc - term;
      term = ((term * x2) >>> 30) / longint'((2 * k + 2) * (2 * k + 3));
    end
    amp = (longint'(1) << (width - 1)) - 1;
    return (amp * acc + (longint'(1) << 29)) >>> 30;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dco_quarter_sin_rom.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dco_quarter_sin_rom : dual-port synchronous quarter-wave sine ROM
// Revision: 1.0
// ----------------------------------------------------------------------------
module dco_quarter_sin_rom
  import dco_pkg::*;
#(
  parameter int ADDR_BITS       = c_DEF_TABLE_ADDR_BITS - 2,
  parameter int DATA_WIDTH      = c_DEF_SIN_WIDTH,
  parameter     TABLE_INIT_FILE = "sin_quarter.mem"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ce,
  input  logic [ADDR_BITS-1:0]  i_addr_a,
  input  logic [ADDR_BITS-1:0]  i_addr_b,
  output logic [DATA_WIDTH-1:0] o_data_a,
  output logic [DATA_WIDTH-1:0] o_data_b
);

  localparam int c_DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] w_table [c_DEPTH];
  logic [DATA_WIDTH-1:0] r_data_a;
  logic [DATA_WIDTH-1:0] r_data_b;

  // Contents are evaluated at elaboration so they always match TABLE_INIT_FILE.
  for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_table
    localparam logic [DATA_WIDTH-1:0] c_ENTRY =
      DATA_WIDTH'(quarter_sin_entry(gi, c_DEPTH, DATA_WIDTH));
    assign w_table[gi] = c_ENTRY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_a <= '0;
      r_data_b <= '0;
    end else if (i_ce) begin
      r_data_a <= w_table[i_addr_a];
      r_data_b <= w_table[i_addr_b];
    end
  end

  assign o_data_a = r_data_a;
  assign o_data_b = r_data_b;

endmodule
`default_nettype wire

// File: rtl/dco_sin_cos_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dco_sin_cos_gen : NCO producing SIN/COS samples; frequency changes at phase wrap.
// Optional macro DCO_PHASE_DITHER_EN adds LFSR phase dither before indexing.
// Revision: 1.0
// ----------------------------------------------------------------------------
module dco_sin_cos_gen
  import dco_pkg::*;
#(
  parameter int PHASE_BITS           = c_DEF_PHASE_BITS,
  parameter int TABLE_ADDR_BITS      = c_DEF_TABLE_ADDR_BITS,
  parameter int SIN_TABLE_DATA_WIDTH = c_DEF_SIN_WIDTH,
  parameter     TABLE_INIT_FILE      = "sin_quarter.mem"
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   CE,
  input  logic [PHASE_BITS-1:0]                  FREQ,
  input  logic                                   FREQ_VALID,
  output logic                                   FREQ_READY,
  output logic signed [SIN_TABLE_DATA_WIDTH-1:0] SIN_VALUE,
  output logic signed [SIN_TABLE_DATA_WIDTH-1:0] COS_VALUE,
  output logic                                   PERIOD_START
);

  localparam int c_AW = TABLE_ADDR_BITS - 2;
  localparam int c_W  = SIN_TABLE_DATA_WIDTH;

  freq_state_e           r_state;
  freq_state_e           w_state_next;
  logic                  w_load;
  logic                  w_apply;
  logic [PHASE_BITS-1:0] r_phase;
  logic [PHASE_BITS-1:0] r_inc;
  logic [PHASE_BITS-1:0] r_pending;
  logic                  r_wrap0;
  logic [PHASE_BITS:0]   w_sum;
  logic [PHASE_BITS-1:0] w_phase_idx;

  assign w_sum      = {1'b0, r_phase} + {1'b0, r_inc};
  assign FREQ_READY = (r_state == ST_IDLE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // A zero increment never wraps, so a pending value is taken immediately then.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_apply      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (CE && FREQ_VALID) begin
          w_load       = 1'b1;
          w_state_next = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (CE && (w_sum[PHASE_BITS] || (r_inc == '0))) begin
          w_apply      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_phase   <= '0;
      r_inc     <= '0;
      r_pending <= '0;
      r_wrap0   <= 1'b0;
    end else if (CE) begin
      r_phase <= w_sum[PHASE_BITS-1:0];
      r_wrap0 <= w_sum[PHASE_BITS];
      if (w_load)  r_pending <= FREQ;
      if (w_apply) r_inc     <= r_pending;
    end
  end

`ifdef DCO_PHASE_DITHER_EN
  localparam logic [PHASE_BITS-1:0] c_DITHER_MASK = {PHASE_BITS{1'b1}} >> TABLE_ADDR_BITS;

  logic [15:0]            r_lfsr;
  logic [PHASE_BITS+15:0] w_lfsr_ext;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)   r_lfsr <= c_LFSR_SEED;
    else if (CE) r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? c_LFSR_POLY : 16'h0000);
  end

  assign w_lfsr_ext  = {{PHASE_BITS{1'b0}}, r_lfsr};
  assign w_phase_idx = r_phase + (w_lfsr_ext[PHASE_BITS-1:0] & c_DITHER_MASK);
`else
  assign w_phase_idx = r_phase;
`endif

  logic [TABLE_ADDR_BITS-1:0] w_idx;
  logic [1:0]                 w_quad;
  logic [c_AW-1:0]            w_i;
  logic [c_AW-1:0]            w_addr_sin;
  logic [c_AW-1:0]            w_addr_cos;
  logic                       w_neg_sin;
  logic                       w_neg_cos;

  assign w_idx  = w_phase_idx[PHASE_BITS-1 -: TABLE_ADDR_BITS];
  assign w_quad = w_idx[TABLE_ADDR_BITS-1 -: 2];
  assign w_i    = w_idx[c_AW-1:0];

  // Mirrored address Q-1-i is the bitwise complement of i.
  always_comb begin
    w_addr_sin = w_i;
    w_addr_cos = ~w_i;
    w_neg_sin  = 1'b0;
    w_neg_cos  = 1'b0;
    case (w_quad)
      c_QUAD_0: begin
        w_addr_sin = w_i;
        w_addr_cos = ~w_i;
      end
      c_QUAD_1: begin
        w_addr_sin = ~w_i;
        w_addr_cos = w_i;
        w_neg_cos  = 1'b1;
      end
      c_QUAD_2: begin
        w_addr_sin = w_i;
        w_addr_cos = ~w_i;
        w_neg_sin  = 1'b1;
        w_neg_cos  = 1'b1;
      end
      default: begin
        w_addr_sin = ~w_i;
        w_addr_cos = w_i;
        w_neg_sin  = 1'b1;
      end
    endcase
  end

  logic [c_AW-1:0] r_addr_sin;
  logic [c_AW-1:0] r_addr_cos;
  logic            r_neg_sin1;
  logic            r_neg_cos1;
  logic            r_wrap1;
  logic            r_vld1;
  logic            r_neg_sin2;
  logic            r_neg_cos2;
  logic            r_wrap2;
  logic            r_vld2;
  logic [c_W-1:0]  w_rom_sin;
  logic [c_W-1:0]  w_rom_cos;
  logic signed [c_W-1:0] r_sin;
  logic signed [c_W-1:0] r_cos;
  logic                  r_period_start;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_addr_sin <= '0;
      r_addr_cos <= '0;
      r_neg_sin1 <= 1'b0;
      r_neg_cos1 <= 1'b0;
      r_wrap1    <= 1'b0;
      r_vld1     <= 1'b0;
      r_neg_sin2 <= 1'b0;
      r_neg_cos2 <= 1'b0;
      r_wrap2    <= 1'b0;
      r_vld2     <= 1'b0;
    end else if (CE) begin
      r_addr_sin <= w_addr_sin;
      r_addr_cos <= w_addr_cos;
      r_neg_sin1 <= w_neg_sin;
      r_neg_cos1 <= w_neg_cos;
      r_wrap1    <= r_wrap0;
      r_vld1     <= 1'b1;
      r_neg_sin2 <= r_neg_sin1;
      r_neg_cos2 <= r_neg_cos1;
      r_wrap2    <= r_wrap1;
      r_vld2     <= r_vld1;
    end
  end

  dco_quarter_sin_rom #(
    .ADDR_BITS       (c_AW),
    .DATA_WIDTH      (c_W),
    .TABLE_INIT_FILE (TABLE_INIT_FILE)
  ) u_rom (
    .clk      (CLK),
    .rst      (RESET),
    .i_ce     (CE),
    .i_addr_a (r_addr_sin),
    .i_addr_b (r_addr_cos),
    .o_data_a (w_rom_sin),
    .o_data_b (w_rom_cos)
  );

  // Outputs stay zero until the first real table read reaches the last stage.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sin          <= '0;
      r_cos          <= '0;
      r_period_start <= 1'b0;
    end else if (CE && r_vld2) begin
      r_sin          <= r_neg_sin2 ? -$signed(w_rom_sin) : $signed(w_rom_sin);
      r_cos          <= r_neg_cos2 ? -$signed(w_rom_cos) : $signed(w_rom_cos);
      r_period_start <= r_wrap2;
    end
  end

  assign SIN_VALUE    = r_sin;
  assign COS_VALUE    = r_cos;
  assign PERIOD_START = r_period_start;

endmodule
`default_nettype wire
